// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Purpose  : Shares the single-port data memory between the pipeline MEM
//            stage (priority requester) and a secondary DMA/display port.
//            The secondary port is served in cycles where the pipeline does
//            not touch memory. After MAX_WAIT denied cycles it is forced onto
//            the memory for one cycle while the pipeline is stalled.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            memReadM/memWriteM       - pipeline load/store in MEM stage
//            aluResM/writeDataM       - pipeline address / store data
//            readDataM                - pipeline load data (mem_q passthrough)
//            stallM                   - pipeline must hold MEM this cycle
//            sec_req/we/addr/wdata    - secondary request (held until ack)
//            sec_ack/sec_rdata        - secondary completion pulse / data
//            mem_addr/data/wren, mem_q- data memory interface (1-cycle read)
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memReadM,
  input  logic              memWriteM,
  input  logic [ADDR_W-1:0] aluResM,
  input  logic [DATA_W-1:0] writeDataM,
  output logic [DATA_W-1:0] readDataM,
  output logic              stallM,
  input  logic              sec_req,
  input  logic              sec_we,
  input  logic [ADDR_W-1:0] sec_addr,
  input  logic [DATA_W-1:0] sec_wdata,
  output logic              sec_ack,
  output logic [DATA_W-1:0] sec_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    SEC_DATA = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic pipe_use;
  logic force_sec;
  logic sec_grant;

  assign pipe_use = memReadM | memWriteM;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    rdata_d    = rdata_q;
    force_sec  = 1'b0;
    sec_grant  = 1'b0;
    stallM     = 1'b0;
    case (state_q)
      IDLE: begin
        force_sec = sec_req & (wait_cnt_q == CNT_MAX);
        sec_grant = sec_req & (~pipe_use | force_sec);
        stallM    = force_sec & pipe_use;
        if (sec_grant) begin
          state_d    = SEC_DATA;
          wait_cnt_d = '0;
        end else if (sec_req) begin
          // Saturate so a long-denied request keeps asserting force.
          if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end else begin
          wait_cnt_d = '0;
        end
      end
      SEC_DATA: begin
        // sec_req is still high from the request being served; ignore it.
        state_d = IDLE;
        rdata_d = mem_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory mux: the secondary port owns the memory only in its grant cycle.
  assign mem_addr  = sec_grant ? sec_addr  : aluResM;
  assign mem_data  = sec_grant ? sec_wdata : writeDataM;
  // Write enable is gated by reset so no spurious store occurs while resetting.
  assign mem_wren  = ~rst & (sec_grant ? sec_we : memWriteM);

  assign sec_ack   = (state_q == SEC_DATA);
  assign sec_rdata = sec_ack ? mem_q : rdata_q;
  assign readDataM = mem_q;

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Shares the single-port data memory between the pipeline MEM stage and one secondary requester (display/IO DMA port). The pipeline has priority. The secondary port is served in cycles where the pipeline does not access memory. A starvation counter forces one secondary access after MAX_WAIT denied cycles, stalling the pipeline for that cycle. The block sits between the MEM stage and the data memory instance; its stall output feeds the hazard unit.

Parameters:
ADDR_W, 16, address width presented to data memory
DATA_W, 16, data width
MAX_WAIT, 8, denied cycles before a forced secondary grant (must be >= 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
memReadM  in  1  pipeline load in MEM stage
memWriteM  in  1  pipeline store in MEM stage
aluResM  in  ADDR_W  pipeline address
writeDataM  in  DATA_W  pipeline store data
readDataM  out  DATA_W  pipeline load data (valid cycle after access)
stallM  out  1  pipeline must hold MEM stage this cycle
sec_req  in  1  secondary request, held high until sec_ack
sec_we  in  1  secondary write (1) / read (0), stable while sec_req
sec_addr  in  ADDR_W  secondary address, stable while sec_req
sec_wdata  in  DATA_W  secondary write data, stable while sec_req
sec_ack  out  1  one-cycle completion pulse
sec_rdata  out  DATA_W  secondary read data
mem_addr  out  ADDR_W  to data memory address
mem_data  out  DATA_W  to data memory write data
mem_wren  out  1  to data memory write enable
mem_q  in  DATA_W  data memory output, registered (1-cycle read latency)

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, wait_cnt=0, sec_ack=0, sec_rdata=0, stallM=0. mem_wren=0 whenever rst=1.
- pipe_use = memReadM | memWriteM.
- States:
  - IDLE: secondary may be granted.
  - SEC_DATA: the cycle after a secondary grant. sec_req is ignored here because it is still high from the served request.
- Grant decision, combinational, in IDLE:
  - force = sec_req & (wait_cnt == MAX_WAIT)
  - sec_grant = sec_req & (~pipe_use | force)
  - stallM = force & pipe_use
- In SEC_DATA: sec_grant=0 and stallM=0.
- Memory mux:
  - sec_grant=1: mem_addr=sec_addr, mem_data=sec_wdata, mem_wren=sec_we.
  - Otherwise: mem_addr=aluResM, mem_data=writeDataM, mem_wren=memWriteM.
- Transitions:
  - IDLE -> SEC_DATA on sec_grant.
  - SEC_DATA -> IDLE always.
- sec_ack: high exactly during SEC_DATA (one cycle, the cycle after grant), for reads and writes alike.
- sec_rdata:
  - In SEC_DATA: equals mem_q.
  - Otherwise: holds the value latched at the end of the last SEC_DATA cycle.
  - For writes, sec_rdata is updated but is don't-care to the requester.
- readDataM = mem_q, passthrough. After a stalled cycle the pipeline re-presents its access, and the correct data appears one cycle after the non-stalled access.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each IDLE cycle with sec_req=1 & sec_grant=0.
  - Clears on sec_grant.
  - Clears when sec_req=0 in IDLE.
  - Holds in SEC_DATA.
- Simultaneous events:
  - Pipeline and secondary request in the same cycle with wait_cnt<MAX_WAIT: pipeline wins, stallM=0.
  - Same with wait_cnt==MAX_WAIT: secondary wins, stallM=1.
- Back-to-back secondary accesses are spaced by at least one cycle (the SEC_DATA cycle), so max secondary throughput is 1 access per 2 cycles.
- Reset mid-operation: rst during SEC_DATA returns to IDLE next edge with no ack. The in-flight secondary read is lost and the requester re-requests. A memory write issued the cycle before rst completes normally.

Test Plan:
1. Reset hold 3 cycles, all inputs 0 -> stallM=0, sec_ack=0, sec_rdata=0, mem_wren=0.
2. Pipeline idle; sec_req=1, sec_we=1, addr 0x0010, wdata 0xBEEF; then sec_req=1, sec_we=0, addr 0x0010 -> grant same cycle, sec_ack pulse next cycle each time; read sec_rdata=0xBEEF during its ack.
3. Pipeline store addr 0x0020 data 0x1234 concurrent with sec_req read of 0x0020 (wait_cnt=0) -> pipeline write goes first, stallM=0; secondary granted next free cycle, returns 0x1234.
4. memReadM=1 continuously, sec_req=1 held, MAX_WAIT=8 -> 8 denied cycles, 9th cycle stallM=1 with secondary on memory, sec_ack the following cycle, wait_cnt=0 afterwards.
5. Pipeline load of 0x0030 (holding 0x5A5A) issued in the cycle immediately after a forced grant -> readDataM=0x5A5A one cycle later, unaffected by the secondary data.
6. Assert rst during SEC_DATA of a secondary read -> no sec_ack after reset, state IDLE, wait_cnt=0. Re-request completes normally.
